mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits directly downstream of the processor control/datapath memory interface.
- Multiplexes two clients onto one physical memory port: instruction fetch (read-only) and data load/store (read/write).
- Clients hold their request until they see resp, which is the same protocol the control FSM already uses.
- Round-robin arbitration, request latching, a registered busy FSM and a sticky watchdog error flag.

Parameters:
- TIMEOUT, 1023: cycles in BUSY without pmem_resp before err is set. Range 1..65535.
- CNT_W, 16: width of the watchdog counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_read  in  1  instruction client read request, held until i_resp
- i_address  in  32  instruction fetch address
- i_resp  out  1  instruction request complete, single-cycle pulse
- i_rdata  out  32  fetched word, valid when i_resp=1
- d_read  in  1  data client read request, held until d_resp
- d_write  in  1  data client write request, held until d_resp
- d_address  in  32  data address
- d_wdata  in  32  store data
- d_byte_enable  in  4  store byte mask
- d_resp  out  1  data request complete, single-cycle pulse
- d_rdata  out  32  load data, valid when d_resp=1
- pmem_read  out  1  physical memory read
- pmem_write  out  1  physical memory write
- pmem_address  out  32  physical memory address
- pmem_wdata  out  32  physical memory write data
- pmem_byte_enable  out  4  physical memory byte mask
- pmem_resp  in  1  physical memory done
- pmem_rdata  in  32  physical memory read data
- err  out  1  sticky error flag (watchdog timeout or illegal request)

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D. All registers, outputs and err reset asynchronously:
  - state=IDLE, last_grant=INSTR, err=0, counter=0;
  - all pmem_* outputs 0 (pmem_byte_enable=4'b0000), i_resp=d_resp=0.
- IDLE: sample the requests each cycle.
  - Only one client requesting: grant it.
  - Both requesting: grant the client not named in last_grant. The first contention after reset therefore goes to DATA.
  - At the grant edge:
    - latch address, wdata, byte_enable and op (read/write) into request registers;
    - update last_grant;
    - go to BUSY_I or BUSY_D.
  - An instruction request latches byte_enable=4'b1111 and op=read.
- BUSY_x: pmem_read/pmem_write, pmem_address, pmem_wdata and pmem_byte_enable are driven only from the latched registers. Client inputs may change without effect.
- pmem_resp=1 in BUSY_x:
  - x_resp=1 combinationally in that same cycle;
  - x_rdata=pmem_rdata combinationally;
  - next state is IDLE.
- Latency: a request seen in IDLE at cycle 0 gives pmem op asserted in cycle 1. x_resp coincides with pmem_resp.
- Minimum request-to-resp time: 2 cycles, when pmem_resp arrives in cycle 1.
- The mandatory IDLE cycle after each response lets the client drop its held request. A completed request is never re-served.
- The non-granted client's resp stays 0 and its rdata is don't-care.
- Outside BUSY_x, i_rdata and d_rdata read 0.
- Simultaneous d_read and d_write at grant: this is illegal.
  - Treat it as a write.
  - Set err=1 at the grant edge.
- Watchdog:
  - The counter clears on entry to BUSY_x and increments each BUSY cycle without pmem_resp. It saturates at TIMEOUT.
  - When counter==TIMEOUT, set err=1 on the next edge. Keep waiting; there is no abort.
  - err clears only on rst.
- pmem_resp while in IDLE: ignored; no client resp is generated.
- rst asserted mid-transaction: return to IDLE immediately and deassert pmem_*. A pmem_resp arriving later is ignored.

Decomposition:
- Shared package rv32i_types gains:
  - arb_state_t enum {IDLE, BUSY_I, BUSY_D};
  - arb_client_t enum {INSTR, DATA}.
- Reuse the existing rv32i_word and rv32i_mem_wmask typedefs for ports.
- Single module, no sub-modules. The round-robin pick is a few gates and stays inline.

Test Plan:
- Instruction-only read: i_read=1, i_address=0x0000_0060, pmem_resp after 3 cycles with rdata=0x0000_0013.
  - Required: pmem_read high cycles 1-3, i_resp one pulse, i_rdata=0x13, d_resp=0.
- Data store: d_write=1, d_address=0x100, d_wdata=0xDEADBEEF, d_byte_enable=4'b0011.
  - Required: pmem_write=1 with identical address, data and mask; d_resp pulse; pmem_read=0 throughout.
- Contention: i_read and d_read both held from reset, clients each drop their request for one cycle after resp, then reassert.
  - Required grant order: D, I, D, I; one IDLE cycle between grants.
  - Required: each resp pulses exactly once per transaction.
- Input change during BUSY: d_address changes 0x200→0x300 while in BUSY_D.
  - Required: pmem_address stays 0x200 until pmem_resp.
- Watchdog at TIMEOUT=4: grant a read, hold pmem_resp=0.
  - Required: err rises 5 cycles after grant and stays high; after a later pmem_resp, the transaction completes normally.
- Async reset mid-BUSY_I: assert rst between edges.
  - Required: pmem_read drops immediately; state IDLE; err=0; a subsequent pmem_resp pulse yields no i_resp.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I type definitions: bus word/mask typedefs plus the memory arbiter enums.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } arb_client_t;

  localparam rv32i_mem_wmask WMASK_ALL = 4'b1111;

endpackage

// File: rtl/mem_arbiter_if.sv
// One memory port bundle, used for both client ports and the physical memory port.
interface mem_arbiter_if;
  import rv32i_types::*;

  // Handshake: the master raises read or write with address/wdata/byte_enable and
  // holds them until it sees resp. resp is a single-cycle pulse, rdata is valid with it.
  logic           read;
  logic           write;
  rv32i_word      address;
  rv32i_word      wdata;
  rv32i_mem_wmask byte_enable;
  logic           resp;
  rv32i_word      rdata;

  modport master (
    output read, write, address, wdata, byte_enable,
    input  resp, rdata
  );

  modport slave (
    input  read, write, address, wdata, byte_enable,
    output resp, rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter putting the instruction-fetch and data clients onto one memory port,
// with latched requests, a busy FSM and a sticky watchdog/illegal-request error flag.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNT_W   = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  i_bus,
  mem_arbiter_if.slave  d_bus,
  mem_arbiter_if.master pmem,
  output logic          err,
  output arb_state_t    dbg_state
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  arb_state_t     state, state_next;
  arb_client_t    last_grant;
  arb_client_t    grant;
  logic           grant_valid;
  logic           busy;
  logic           illegal;
  logic [CNT_W-1:0] cnt;

  rv32i_word      req_addr;
  rv32i_word      req_wdata;
  rv32i_mem_wmask req_be;
  logic           req_write;

  logic           i_req, d_req;

  // The instruction client is read-only; its write-side fields are never looked at.
  logic unused_i;
  assign unused_i = ^{i_bus.write, i_bus.wdata, i_bus.byte_enable};

  assign i_req   = i_bus.read;
  assign d_req   = d_bus.read | d_bus.write;
  assign busy    = (state != IDLE);
  assign illegal = d_bus.read & d_bus.write;
  assign dbg_state = state;

  always_comb begin
    state_next  = state;
    grant       = INSTR;
    grant_valid = 1'b0;
    case (state)
      IDLE: begin
        // On contention the client that did not win last time goes first.
        if (i_req && d_req) begin
          grant       = (last_grant == INSTR) ? DATA : INSTR;
          grant_valid = 1'b1;
        end else if (d_req) begin
          grant       = DATA;
          grant_valid = 1'b1;
        end else if (i_req) begin
          grant       = INSTR;
          grant_valid = 1'b1;
        end
        if (grant_valid) begin
          state_next = (grant == DATA) ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (pmem.resp) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= INSTR;
      err        <= 1'b0;
      cnt        <= '0;
      req_addr   <= '0;
      req_wdata  <= '0;
      req_be     <= '0;
      req_write  <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_valid) begin
        last_grant <= grant;
        cnt        <= '0;
        if (grant == DATA) begin
          req_addr  <= d_bus.address;
          req_wdata <= d_bus.wdata;
          req_be    <= d_bus.byte_enable;
          // read+write together is resolved as a write and flagged.
          req_write <= d_bus.write;
          if (illegal) begin
            err <= 1'b1;
          end
        end else begin
          req_addr  <= i_bus.address;
          req_wdata <= '0;
          req_be    <= WMASK_ALL;
          req_write <= 1'b0;
        end
      end else if (busy && !pmem.resp && (cnt != TMO)) begin
        cnt <= cnt + 1'b1;
      end
      if (busy && (cnt == TMO)) begin
        err <= 1'b1;
      end
    end
  end

  // Memory-side outputs come only from the latched request while busy.
  always_comb begin
    pmem.read        = busy & ~req_write;
    pmem.write       = busy & req_write;
    pmem.address     = busy ? req_addr  : '0;
    pmem.wdata       = busy ? req_wdata : '0;
    pmem.byte_enable = busy ? req_be    : '0;
  end

  always_comb begin
    i_bus.resp  = (state == BUSY_I) & pmem.resp;
    d_bus.resp  = (state == BUSY_D) & pmem.resp;
    i_bus.rdata = (state == BUSY_I) ? pmem.rdata : '0;
    d_bus.rdata = (state == BUSY_D) ? pmem.rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-client transfers, contention, watchdog and async reset.
module tb_mem_arbiter;
  import rv32i_types::*;

  logic clk;
  logic rst;
  logic err;
  arb_state_t dbg_state;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  mem_arbiter_if i_bus();
  mem_arbiter_if d_bus();
  mem_arbiter_if pmem();

  mem_arbiter #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_bus     (i_bus),
    .d_bus     (d_bus),
    .pmem      (pmem),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    i_bus.read = 0; i_bus.write = 0; i_bus.address = '0; i_bus.wdata = '0; i_bus.byte_enable = '0;
    d_bus.read = 0; d_bus.write = 0; d_bus.address = '0; d_bus.wdata = '0; d_bus.byte_enable = '0;
    pmem.resp = 0; pmem.rdata = '0;
  endtask

  initial begin
    logic [31:0] exp_g;
    checks = 0;
    errors = 0;
    clear_inputs();
    rst = 1'b1;
    #2;
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_err", 32'(err), 32'd0);
    check("rst_pmem_rw", {30'd0, pmem.read, pmem.write}, 32'd0);
    check("rst_pmem_be", 32'(pmem.byte_enable), 32'd0);
    check("rst_resp", {30'd0, i_bus.resp, d_bus.resp}, 32'd0);
    #10 rst = 1'b0;   // t=12, between edges
    tick();

    // instruction-only read, pmem_resp in cycle 3
    i_bus.read = 1; i_bus.address = 32'h0000_0060;
    tick();
    #1;
    check("i1_state", 32'(dbg_state), 32'(BUSY_I));
    check("i1_read_c1", 32'(pmem.read), 32'd1);
    check("i1_addr", pmem.address, 32'h0000_0060);
    check("i1_be", 32'(pmem.byte_enable), 32'hF);
    check("i1_write", 32'(pmem.write), 32'd0);
    tick();
    #1;
    check("i1_read_c2", 32'(pmem.read), 32'd1);
    check("i1_noresp_c2", 32'(i_bus.resp), 32'd0);
    tick();
    pmem.resp = 1; pmem.rdata = 32'h0000_0013;
    #1;
    check("i1_read_c3", 32'(pmem.read), 32'd1);
    check("i1_resp", 32'(i_bus.resp), 32'd1);
    check("i1_rdata", i_bus.rdata, 32'h0000_0013);
    check("i1_dresp", 32'(d_bus.resp), 32'd0);
    i_bus.read = 0;
    tick();
    pmem.resp = 0;
    #1;
    check("i1_idle", 32'(dbg_state), 32'(IDLE));
    check("i1_resp_once", 32'(i_bus.resp), 32'd0);
    check("i1_read_off", 32'(pmem.read), 32'd0);
    check("i1_rdata_idle", i_bus.rdata, 32'd0);

    // data store
    d_bus.write = 1; d_bus.address = 32'h100; d_bus.wdata = 32'hDEADBEEF; d_bus.byte_enable = 4'b0011;
    tick();
    #1;
    check("st_write", 32'(pmem.write), 32'd1);
    check("st_read", 32'(pmem.read), 32'd0);
    check("st_addr", pmem.address, 32'h100);
    check("st_wdata", pmem.wdata, 32'hDEADBEEF);
    check("st_be", 32'(pmem.byte_enable), 32'h3);
    pmem.resp = 1;
    #1;
    check("st_dresp", 32'(d_bus.resp), 32'd1);
    check("st_iresp", 32'(i_bus.resp), 32'd0);
    check("st_read_resp", 32'(pmem.read), 32'd0);
    d_bus.write = 0;
    tick();
    pmem.resp = 0;
    #1;
    check("st_idle", 32'(dbg_state), 32'(IDLE));
    check("st_dresp_once", 32'(d_bus.resp), 32'd0);
    check("st_err", 32'(err), 32'd0);

    // contention from reset: expected grant order D, I, D, I
    rst = 1'b1;
    clear_inputs();
    i_bus.read = 1; i_bus.address = 32'h0000_0400;
    d_bus.read = 1; d_bus.address = 32'h0000_0800;
    exp_q.push_back(32'(BUSY_D));
    exp_q.push_back(32'(BUSY_I));
    exp_q.push_back(32'(BUSY_D));
    exp_q.push_back(32'(BUSY_I));
    #1 rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      exp_g = exp_q.pop_front();
      check("cont_grant", 32'(dbg_state), exp_g);
      pmem.resp = 1; pmem.rdata = 32'h1000 + 32'(t);
      #1;
      if (exp_g == 32'(BUSY_D)) begin
        check("cont_dresp", {30'd0, i_bus.resp, d_bus.resp}, 32'd1);
        check("cont_drdata", d_bus.rdata, 32'h1000 + 32'(t));
        check("cont_daddr", pmem.address, 32'h0000_0800);
        d_bus.read = 0;
      end else begin
        check("cont_iresp", {30'd0, i_bus.resp, d_bus.resp}, 32'd2);
        check("cont_irdata", i_bus.rdata, 32'h1000 + 32'(t));
        check("cont_iaddr", pmem.address, 32'h0000_0400);
        i_bus.read = 0;
      end
      tick();
      pmem.resp = 0;
      #1;
      check("cont_idle", 32'(dbg_state), 32'(IDLE));
      check("cont_resp_once", {30'd0, i_bus.resp, d_bus.resp}, 32'd0);
      if (t < 3) begin
        i_bus.read = 1;
        d_bus.read = 1;
      end else begin
        i_bus.read = 0;
        d_bus.read = 0;
      end
    end
    check("cont_q_empty", 32'(exp_q.size()), 32'd0);

    // client input change while busy
    tick();
    d_bus.read = 1; d_bus.address = 32'h200;
    tick();
    #1;
    check("chg_addr0", pmem.address, 32'h200);
    d_bus.address = 32'h300;
    #1;
    check("chg_addr1", pmem.address, 32'h200);
    tick();
    #1;
    check("chg_addr2", pmem.address, 32'h200);
    pmem.resp = 1; pmem.rdata = 32'h5555_AAAA;
    #1;
    check("chg_addr_resp", pmem.address, 32'h200);
    check("chg_dresp", 32'(d_bus.resp), 32'd1);
    d_bus.read = 0;
    tick();
    pmem.resp = 0;

    // watchdog at TIMEOUT=4: err rises 5 edges after the grant edge
    i_bus.read = 1; i_bus.address = 32'h40;
    tick();  // grant edge
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("wd_err_low", 32'(err), 32'd0);
    end
    tick();
    check("wd_err_rise", 32'(err), 32'd1);
    tick();
    check("wd_err_hold", 32'(err), 32'd1);
    check("wd_still_busy", 32'(pmem.read), 32'd1);
    pmem.resp = 1; pmem.rdata = 32'h0000_00AA;
    #1;
    check("wd_iresp", 32'(i_bus.resp), 32'd1);
    check("wd_irdata", i_bus.rdata, 32'h0000_00AA);
    i_bus.read = 0;
    tick();
    pmem.resp = 0;
    #1;
    check("wd_idle", 32'(dbg_state), 32'(IDLE));
    check("wd_err_sticky", 32'(err), 32'd1);

    // async reset in the middle of BUSY_I
    i_bus.read = 1; i_bus.address = 32'h80;
    tick();
    #1;
    check("ar_busy", 32'(pmem.read), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_read_drop", 32'(pmem.read), 32'd0);
    check("ar_state", 32'(dbg_state), 32'(IDLE));
    check("ar_err", 32'(err), 32'd0);
    i_bus.read = 0;
    #2 rst = 1'b0;
    tick();
    pmem.resp = 1; pmem.rdata = 32'h1234_5678;
    #1;
    check("ar_no_iresp", 32'(i_bus.resp), 32'd0);
    check("ar_no_rdata", i_bus.rdata, 32'd0);
    tick();
    pmem.resp = 0;
    #1;
    check("ar_idle", 32'(dbg_state), 32'(IDLE));

    // illegal read+write on the data client: served as a write, err at grant edge
    d_bus.read = 1; d_bus.write = 1; d_bus.address = 32'h500; d_bus.wdata = 32'hCAFE_F00D; d_bus.byte_enable = 4'b1100;
    tick();
    #1;
    check("ill_write", {30'd0, pmem.read, pmem.write}, 32'd1);
    check("ill_err", 32'(err), 32'd1);
    check("ill_wdata", pmem.wdata, 32'hCAFE_F00D);
    pmem.resp = 1;
    #1;
    check("ill_dresp", 32'(d_bus.resp), 32'd1);
    d_bus.read = 0; d_bus.write = 0;
    tick();
    pmem.resp = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
